// File: rtl/conv1d_pe_multi.sv
// conv1d_pe_multi: 1-D convolution PE applying NUM_FILTERS filters per window over FIFO-fed rows.
module conv1d_pe_multi #(
  parameter int DATA_WIDTH        = 16,
  parameter int FILTER_SIZE_WIDTH = 3,
  parameter int STRIDE_WIDTH      = 2,
  parameter int IFMAP_DEPTH       = 16,
  parameter int NUM_FILTERS       = 2,
  parameter int ROWS_WIDTH        = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          Start,
  input  logic [STRIDE_WIDTH-1:0]       stride_in,
  input  logic [FILTER_SIZE_WIDTH-1:0]  filter_size_in,
  input  logic [1:0]                    mode_in,
  input  logic [ROWS_WIDTH-1:0]         num_rows_in,
  output logic                          ready,
  output logic                          done,
  input  logic [DATA_WIDTH+1:0]         IFMap,
  input  logic                          valid_IFMap,
  output logic                          ren_buf_IFMap,
  input  logic signed [DATA_WIDTH-1:0]  Filter,
  input  logic                          valid_Filter,
  output logic                          ren_buf_Filter,
  input  logic signed [DATA_WIDTH-1:0]  input_Psum,
  input  logic                          valid_input_Psum,
  output logic                          ren_buf_input_Psum,
  output logic signed [DATA_WIDTH-1:0]  Psum,
  input  logic                          ready_Psum,
  output logic                          wen_buf_Psum
);
  localparam int FMAX = (1 << FILTER_SIZE_WIDTH) - 1;
  localparam int NW   = NUM_FILTERS * FMAX;
  localparam int WI   = NW > 1 ? $clog2(NW) : 1;
  localparam int AW   = IFMAP_DEPTH > 1 ? $clog2(IFMAP_DEPTH) : 1;
  localparam int PW   = $clog2(IFMAP_DEPTH + 1) + STRIDE_WIDTH + FILTER_SIZE_WIDTH;
  localparam int FW   = NUM_FILTERS > 1 ? $clog2(NUM_FILTERS) : 1;
  localparam int ACCW = 2 * DATA_WIDTH + FILTER_SIZE_WIDTH;
  localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, LOAD_FILT, LOAD_ROW, COMPUTE} state_t;
  typedef enum logic [1:0] {MAC, PSUM_WAIT, OUT} phase_t;

  state_t                        state, state_n;
  phase_t                        phase;
  logic [STRIDE_WIDTH-1:0]       stride_q;
  logic [FILTER_SIZE_WIDTH-1:0]  size_q, k;
  logic                          mode_q, in_row, done_q;
  logic [ROWS_WIDTH-1:0]         rows_q, row_cnt;
  logic [PW-1:0]                 row_len, p;
  logic [FW-1:0]                 f;
  logic [WI-1:0]                 lcnt;
  logic signed [ACCW-1:0]        acc, acc_tap, acc_ps;
  logic signed [DATA_WIDTH-1:0]  psum_q, ws, xs;
  logic signed [DATA_WIDTH-1:0]  wbuf [NW];
  logic signed [DATA_WIDTH-1:0]  rbuf [IFMAP_DEPTH];
  logic                          last_w, last_tap, last_f, last_row, win_ok, row_fin, row_start;
  logic                          unused;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACCW-1:0] a);
    return (a > SMAX) ? SMAX[DATA_WIDTH-1:0] : (a < SMIN) ? SMIN[DATA_WIDTH-1:0] : a[DATA_WIDTH-1:0];
  endfunction

  assign unused    = mode_in[1];
  assign ready     = state == IDLE;
  assign done      = done_q;
  assign Psum      = psum_q;
  assign ws        = wbuf[WI'(f) * WI'(size_q) + WI'(k)];
  assign xs        = rbuf[AW'(p + PW'(k))];
  assign acc_tap   = acc + ACCW'(ws) * ACCW'(xs);
  assign acc_ps    = acc + ACCW'(input_Psum);
  assign last_w    = lcnt == WI'(NUM_FILTERS * size_q - 1);
  assign last_tap  = k == size_q - FILTER_SIZE_WIDTH'(1);
  assign last_f    = f == FW'(NUM_FILTERS - 1);
  assign last_row  = row_cnt == rows_q - ROWS_WIDTH'(1);
  assign win_ok    = p + PW'(size_q) <= row_len;
  assign row_start = IFMap[DATA_WIDTH+1];
  // a row finishes on an end-tagged word that is either inside a row or opens one itself
  assign row_fin   = valid_IFMap && IFMap[DATA_WIDTH] && (row_start || in_row);

  always_comb begin
    state_n            = state;
    ren_buf_Filter     = 1'b0;
    ren_buf_IFMap      = 1'b0;
    ren_buf_input_Psum = 1'b0;
    wen_buf_Psum       = 1'b0;
    unique case (state)
      IDLE:      state_n = (Start && num_rows_in != '0) ? LOAD_FILT : IDLE;
      LOAD_FILT: begin
        ren_buf_Filter = valid_Filter;
        state_n        = (valid_Filter && last_w) ? LOAD_ROW : LOAD_FILT;
      end
      LOAD_ROW:  begin
        ren_buf_IFMap = valid_IFMap;
        state_n       = row_fin ? COMPUTE : LOAD_ROW;
      end
      COMPUTE:   begin
        ren_buf_input_Psum = phase == PSUM_WAIT && valid_input_Psum;
        wen_buf_Psum       = phase == OUT && ready_Psum;
        state_n            = (phase == MAC && !win_ok) ? (last_row ? IDLE : LOAD_ROW) : COMPUTE;
      end
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == LOAD_ROW && valid_IFMap && (row_start || (in_row && row_len < PW'(IFMAP_DEPTH))))
      rbuf[row_start ? '0 : AW'(row_len)] <= IFMap[DATA_WIDTH-1:0];
    if (ren_buf_Filter)
      wbuf[lcnt] <= Filter;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= MAC;
      stride_q <= '0;
      size_q   <= '0;
      mode_q   <= 1'b0;
      rows_q   <= '0;
      row_cnt  <= '0;
      row_len  <= '0;
      in_row   <= 1'b0;
      p        <= '0;
      f        <= '0;
      k        <= '0;
      lcnt     <= '0;
      acc      <= '0;
      psum_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (Start) begin
          stride_q <= stride_in == '0 ? STRIDE_WIDTH'(1) : stride_in;
          size_q   <= filter_size_in == '0 ? FILTER_SIZE_WIDTH'(1) : filter_size_in;
          mode_q   <= mode_in[0];
          rows_q   <= num_rows_in;
          row_cnt  <= '0;
          lcnt     <= '0;
          done_q   <= num_rows_in == '0;
        end
        LOAD_FILT: if (valid_Filter) lcnt <= last_w ? '0 : lcnt + WI'(1);
        LOAD_ROW: if (valid_IFMap) begin
          if (row_start) begin
            row_len <= PW'(1);
            in_row  <= !IFMap[DATA_WIDTH];
          end else if (in_row) begin
            row_len <= row_len < PW'(IFMAP_DEPTH) ? row_len + PW'(1) : row_len;
            in_row  <= !IFMap[DATA_WIDTH];
          end
          if (row_fin) begin
            p     <= '0;
            f     <= '0;
            k     <= '0;
            acc   <= '0;
            phase <= MAC;
          end
        end
        COMPUTE: unique case (phase)
          MAC: if (!win_ok) begin
            row_cnt <= row_cnt + ROWS_WIDTH'(1);
            done_q  <= last_row;
          end else begin
            acc <= acc_tap;
            k   <= last_tap ? '0 : k + FILTER_SIZE_WIDTH'(1);
            if (last_tap) begin
              phase <= mode_q ? PSUM_WAIT : OUT;
              if (!mode_q) psum_q <= sat(acc_tap);
            end
          end
          PSUM_WAIT: if (valid_input_Psum) begin
            psum_q <= sat(acc_ps);
            phase  <= OUT;
          end
          OUT: if (ready_Psum) begin
            acc   <= '0;
            phase <= MAC;
            f     <= last_f ? '0 : f + FW'(1);
            if (last_f) p <= p + PW'(stride_q);
          end
          default: phase <= MAC;
        endcase
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv1d_pe_multi.sv
// tb_conv1d_pe_multi: randomized FIFO-driven bench with a window-level reference model.
module tb_conv1d_pe_multi;
  localparam int NF = 2, DEPTH = 16;
  logic clk = 0, rst = 1, Start = 0;
  logic [1:0] stride_in = 0, mode_in = 0;
  logic [2:0] filter_size_in = 0;
  logic [5:0] num_rows_in = 0;
  logic ready, done, valid_IFMap, ren_buf_IFMap, valid_Filter, ren_buf_Filter;
  logic valid_input_Psum, ren_buf_input_Psum, ready_Psum, wen_buf_Psum;
  logic [17:0] IFMap;
  logic signed [15:0] Filter, input_Psum, Psum;

  conv1d_pe_multi dut (.clk(clk), .rst(rst), .Start(Start), .stride_in(stride_in),
    .filter_size_in(filter_size_in), .mode_in(mode_in), .num_rows_in(num_rows_in),
    .ready(ready), .done(done), .IFMap(IFMap), .valid_IFMap(valid_IFMap),
    .ren_buf_IFMap(ren_buf_IFMap), .Filter(Filter), .valid_Filter(valid_Filter),
    .ren_buf_Filter(ren_buf_Filter), .input_Psum(input_Psum), .valid_input_Psum(valid_input_Psum),
    .ren_buf_input_Psum(ren_buf_input_Psum), .Psum(Psum), .ready_Psum(ready_Psum),
    .wen_buf_Psum(wen_buf_Psum));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [17:0] ifq[$];
  int fq[$], pq[$], exp_q[$];
  int w[NF][8], rdat[8][24], rlen[8];
  int pops_f, pops_i, pops_p, stall_n, chg, last_ps;
  bit gate, stall_req, seen_done;

  task automatic check(string tag, int got, int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  function automatic int sat(longint a);
    return a > 32767 ? 32767 : a < -32768 ? -32768 : int'(a);
  endfunction

  task automatic drive();
    valid_Filter     = fq.size() > 0 && (!gate || $urandom_range(3) != 0);
    Filter           = fq.size() > 0 ? 16'(fq[0]) : 16'd0;
    valid_IFMap      = ifq.size() > 0 && (!gate || $urandom_range(3) != 0);
    IFMap            = ifq.size() > 0 ? ifq[0] : 18'd0;
    valid_input_Psum = pq.size() > 0 && (!gate || $urandom_range(3) != 0);
    input_Psum       = pq.size() > 0 ? 16'(pq[0]) : 16'd0;
    ready_Psum       = stall_n > 0 ? 1'b0 : (!gate || $urandom_range(3) != 0);
  endtask

  task automatic step();
    bit pf, pi, pp;
    @(negedge clk);
    if (ren_buf_Filter) check("ren_filter_valid", int'(valid_Filter), 1);
    if (ren_buf_IFMap) check("ren_ifmap_valid", int'(valid_IFMap), 1);
    if (ren_buf_input_Psum) check("ren_psum_valid", int'(valid_input_Psum), 1);
    if (wen_buf_Psum) begin
      check("wen_ready", int'(ready_Psum), 1);
      if (exp_q.size() == 0) check("extra_psum", 1, 0);
      else check("psum", int'(Psum), exp_q.pop_front());
    end
    if (stall_n > 0) begin
      check("stall_wen", int'(wen_buf_Psum), 0);
      if (int'(Psum) != last_ps) chg++;
      last_ps = int'(Psum);
      stall_n--;
      if (stall_n == 0) check("stall_psum_changes", int'(chg <= 1), 1);
    end else if (wen_buf_Psum && stall_req) begin
      stall_req = 0;
      stall_n   = 8;
      chg       = 0;
      last_ps   = int'(Psum);
    end
    if (done) seen_done = 1;
    pf = ren_buf_Filter && valid_Filter;
    pi = ren_buf_IFMap && valid_IFMap;
    pp = ren_buf_input_Psum && valid_input_Psum;
    @(posedge clk);
    #1;
    if (pf) begin void'(fq.pop_front()); pops_f++; end
    if (pi) begin void'(ifq.pop_front()); pops_i++; end
    if (pp) begin void'(pq.pop_front()); pops_p++; end
    drive();
  endtask

  task automatic clear();
    ifq.delete(); fq.delete(); pq.delete(); exp_q.delete();
  endtask

  // Queue the FIFO contents of a job and, optionally, its expected outputs and psums
  task automatic build(int fs, int st, bit md, int nr, bit use_model);
    int sz = fs == 0 ? 1 : fs;
    int s  = st == 0 ? 1 : st;
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < sz; k++) fq.push_back(w[f][k]);
    for (int r = 0; r < nr; r++) begin
      int junk = $urandom_range(2);
      for (int j = 0; j < junk; j++) ifq.push_back({1'b0, 1'($urandom_range(1)), 16'($urandom)});
      for (int i = 0; i < rlen[r]; i++) ifq.push_back({i == 0, i == rlen[r] - 1, 16'(rdat[r][i])});
    end
    if (use_model)
      for (int r = 0; r < nr; r++) begin
        int n = rlen[r] > DEPTH ? DEPTH : rlen[r];
        for (int p = 0; p + sz <= n; p += s)
          for (int f = 0; f < NF; f++) begin
            longint acc = 0;
            for (int k = 0; k < sz; k++) acc += longint'(w[f][k]) * rdat[r][p + k];
            if (md) begin
              int pv = int'($signed(16'($urandom)));
              pq.push_back(pv);
              acc += pv;
            end
            exp_q.push_back(sat(acc));
          end
      end
  endtask

  task automatic run(int fs, int st, bit md, int nr, string tag);
    int n_p  = pq.size();
    int n_i  = ifq.size();
    int sz   = fs == 0 ? 1 : fs;
    int cyc  = 0;
    pops_f = 0; pops_i = 0; pops_p = 0; seen_done = 0;
    stride_in = 2'(st); filter_size_in = 3'(fs); num_rows_in = 6'(nr);
    mode_in = {1'($urandom_range(1)), md};
    Start = 1;
    step();
    Start = 0;
    if (nr != 0) check({tag, "_busy"}, int'(ready), 0);
    while (!seen_done && cyc < 4000) begin
      step();
      cyc++;
    end
    check({tag, "_done"}, int'(seen_done), 1);
    if (nr == 0) check({tag, "_done_latency"}, cyc, 1);
    check({tag, "_outputs_left"}, exp_q.size(), 0);
    check({tag, "_psum_pops"}, pops_p, n_p);
    check({tag, "_filter_pops"}, pops_f, nr == 0 ? 0 : NF * sz);
    check({tag, "_ifmap_pops"}, pops_i, nr == 0 ? 0 : n_i);
    step();
    check({tag, "_idle"}, int'(ready), 1);
  endtask

  task automatic set_basic();
    w[0][0] = 1; w[0][1] = 1; w[0][2] = 1;
    w[1][0] = 1; w[1][1] = 0; w[1][2] = -1;
    rlen[0] = 5;
    for (int i = 0; i < 5; i++) rdat[0][i] = i + 1;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_ready"}, int'(ready), 1);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_psum"}, int'(Psum), 0);
    check({tag, "_strobes"}, int'({wen_buf_Psum, ren_buf_Filter, ren_buf_IFMap, ren_buf_input_Psum}), 0);
  endtask

  initial begin
    drive();
    repeat (3) step();
    rst = 0;
    check_idle_outputs("reset");

    clear(); set_basic(); build(3, 1, 0, 1, 0);
    exp_q = '{6, -2, 9, -2, 12, -2};
    run(3, 1, 0, 1, "basic");

    clear(); set_basic(); build(3, 2, 1, 1, 0);
    pq = '{10, 5, 20, 7};
    exp_q = '{16, 3, 32, 5};
    run(3, 2, 1, 1, "psum_add");

    clear(); w[0][0] = 32767; w[1][0] = -32768; rlen[0] = 1; rdat[0][0] = 2;
    build(1, 1, 0, 1, 0);
    exp_q = '{32767, -32768};
    run(1, 1, 0, 1, "saturate");

    clear(); ifq.push_back(18'h2_0001);
    run(3, 1, 0, 0, "zero_rows");
    clear();

    clear(); w[0][0] = 1; w[1][0] = 2; rlen[0] = 2; rdat[0][0] = 4; rdat[0][1] = 5;
    build(3, 1, 1, 1, 1);
    run(3, 1, 1, 1, "short_row");

    clear(); set_basic(); build(3, 1, 0, 1, 0);
    exp_q = '{6, -2, 9, -2, 12, -2};
    stride_in = 2'd1; filter_size_in = 3'd3; mode_in = 2'd0; num_rows_in = 6'd1;
    Start = 1;
    step();
    Start = 0;
    for (int c = 0; c < 200 && exp_q.size() == 6; c++) step();
    check("rst_reached_compute", exp_q.size(), 5);
    rst = 1;
    step();
    check_idle_outputs("midjob_rst");
    rst = 0;
    clear(); set_basic(); build(3, 1, 0, 1, 0);
    exp_q = '{6, -2, 9, -2, 12, -2};
    run(3, 1, 0, 1, "after_rst");

    gate = 1;
    for (int j = 0; j < 14; j++) begin
      int fs = $urandom_range(7), st = $urandom_range(3), nr = $urandom_range(1, 4);
      bit md = 1'($urandom_range(1)), big = 1'($urandom_range(1));
      clear();
      for (int f = 0; f < NF; f++)
        for (int k = 0; k < 8; k++) w[f][k] = big ? int'($signed(16'($urandom))) : $urandom_range(14) - 7;
      for (int r = 0; r < nr; r++) begin
        rlen[r] = $urandom_range(1, 20);
        for (int i = 0; i < rlen[r]; i++) rdat[r][i] = big ? int'($signed(16'($urandom))) : $urandom_range(20) - 10;
      end
      if (j == 3) begin
        fs = 3; nr = 2; rlen[0] = 12; rlen[1] = 12;
        stall_req = 1;
      end
      build(fs, st, md, nr, 1);
      run(fs, st, md, nr, $sformatf("rand%0d", j));
    end
    check("stall_exercised", int'(stall_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
